// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width and the default
// parameters of the ALU result buffer.
package alu_pkg;

  // ALU operation encoding (bitwise logic unit).
  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_NAND  = 3'd1,
    OP_OR    = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOT_A = 3'd6,
    OP_NOT_B = 3'd7
  } op_code_t;

  // ALU result width; the result buffer data path matches it.
  localparam int ALU_DATA_W = 32;

  // Default geometry of alu_result_buffer.
  localparam int RB_DEPTH = 8;
  localparam int RB_SEQ_W = 8;
  localparam int RB_CNT_W = 16;

endpackage : alu_pkg

// File: rtl/alu_result_buffer_if.sv
// Result stream bundle between the ALU, the result buffer and the consumer.
// The ALU side has no ready: the buffer must always accept (or drop) a beat.
interface alu_result_buffer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DATA_W,
  parameter int SEQ_W = RB_SEQ_W
);

  // ALU -> buffer (no back-pressure)
  logic             in_valid;
  logic [WIDTH-1:0] in_data;

  // buffer -> consumer (valid/ready)
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SEQ_W-1:0] out_seq;

  // Environment side: produces ALU beats and consumes buffered results.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_seq
  );

  // Buffer side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_seq
  );

endinterface : alu_result_buffer_if

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO. Read data is taken straight from the head entry
// so a beat written at one edge is visible in the following cycle, and the
// output reads zero while the FIFO is empty so stale storage never leaks out.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic push_en;
  logic pop_en;

  // Status straight from the occupancy register.
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // A pop on an empty FIFO is ignored; a push on a full FIFO is only
  // accepted when a pop frees the head slot in the same cycle.
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);

  // Head entry, forced to zero while nothing is stored.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents are not reset, the empty mask hides them.
  always_ff @(posedge clock_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule : sync_fifo

// File: rtl/alu_result_buffer.sv
// ALU result buffer: tags every ALU beat with a running sequence number,
// stores it in a FIFO and streams it to the consumer. Beats that find the
// FIFO full (and not draining this cycle) are dropped and counted.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = RB_DEPTH,
  parameter int WIDTH = ALU_DATA_W,
  parameter int SEQ_W = RB_SEQ_W,
  parameter int CNT_W = RB_CNT_W,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  alu_result_buffer_if.slave bus,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] drop_count,
  input  logic             drop_clear
);

  localparam int ENTRY_W = SEQ_W + WIDTH;

  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;
  logic [CNT_W-1:0]   cnt_base;

  logic               pop;
  logic               push_ok;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Handshake decode. The head is only offered when something is stored,
  // so out_ready on an empty buffer is harmless.
  assign bus.out_valid = ~fifo_empty;
  assign pop           = ~fifo_empty & bus.out_ready;
  assign push_ok       = bus.in_valid & (~fifo_full | pop);
  assign drop          = bus.in_valid & fifo_full & ~pop;

  // Entry layout: tag in the upper bits, ALU data below.
  assign wr_entry     = {seq_q, bus.in_data};
  assign bus.out_data = rd_entry[WIDTH-1:0];
  assign bus.out_seq  = rd_entry[ENTRY_W-1:WIDTH];

  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign drop_count = drop_count_q;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i (clock),
    .reset_i (reset),
    .push_i  (push_ok),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // Tag advances on every ALU beat, stored or dropped, so a gap in out_seq
  // downstream marks exactly where beats were lost.
  always_comb begin
    seq_d = seq_q;
    if (bus.in_valid) begin
      seq_d = seq_q + SEQ_W'(1);
    end
  end

  // Drop counter: clear takes effect first, then a same-cycle drop counts
  // on top of it; the counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_base     = drop_clear ? '0 : drop_count_q;
    drop_count_d = cnt_base;
    if (drop && (cnt_base != '1)) begin
      drop_count_d = cnt_base + CNT_W'(1);
    end
  end

  // Tag and drop counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q        <= '0;
      drop_count_q <= '0;
    end else begin
      seq_q        <= seq_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule : alu_result_buffer

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: reset values, a table of short
// vectors, hand-written corner sequences and a randomized run against a
// queue-based reference model.
module tb_alu_result_buffer;

  localparam int DEPTH  = 8;
  localparam int WIDTH  = 32;
  localparam int SEQ_W  = 8;
  localparam int CNT_W  = 16;
  localparam int CNT_W2 = 4;
  localparam int LVL_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              drop_clear;
  logic              drop_clear2;
  logic [LVL_W-1:0]  level, level2;
  logic              full, empty, full2, empty2;
  logic [CNT_W-1:0]  drop_count;
  logic [CNT_W2-1:0] drop_count2;

  alu_result_buffer_if #(.WIDTH(WIDTH), .SEQ_W(SEQ_W)) bus ();
  alu_result_buffer_if #(.WIDTH(WIDTH), .SEQ_W(SEQ_W)) bus2 ();

  alu_result_buffer #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clk), .reset(rst), .bus(bus), .level(level), .full(full),
    .empty(empty), .drop_count(drop_count), .drop_clear(drop_clear)
  );

  // Narrow drop counter instance for the saturation check.
  alu_result_buffer #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W2)
  ) dut_sat (
    .clock(clk), .reset(rst), .bus(bus2), .level(level2), .full(full2),
    .empty(empty2), .drop_count(drop_count2), .drop_clear(drop_clear2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of stored beats plus tag and drop counters.
  typedef struct {
    logic [7:0]  seq;
    logic [31:0] data;
  } entry_t;
  entry_t mq[$];
  int     mtag;
  int     mdrop;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        rdy;
    logic        clr;
    logic        e_ov;
    logic [31:0] e_data;
    logic [7:0]  e_seq;
    logic [3:0]  e_lvl;
    logic [15:0] e_drop;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Beat-level behaviour: head leaves first if offered and accepted; a new
  // beat is stored if there was room before the edge or the head left.
  task automatic model_step(input logic iv, input logic [31:0] d, input logic rdy, input logic clr);
    bit was_full;
    bit popped;
    was_full = (mq.size() == DEPTH);
    popped   = (mq.size() > 0) && rdy;
    if (popped) void'(mq.pop_front());
    if (clr) mdrop = 0;
    if (iv) begin
      if (!was_full || popped) mq.push_back('{seq: mtag[7:0], data: d});
      else if (mdrop < 65535) mdrop++;
      mtag = (mtag + 1) % 256;
    end
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("model.out_valid", 64'(bus.out_valid), 64'(sz > 0));
    chk("model.out_data", 64'(bus.out_data), (sz > 0) ? 64'(mq[0].data) : 64'd0);
    chk("model.out_seq", 64'(bus.out_seq), (sz > 0) ? 64'(mq[0].seq) : 64'd0);
    chk("model.level", 64'(level), 64'(sz));
    chk("model.full", 64'(full), 64'(sz == DEPTH));
    chk("model.empty", 64'(empty), 64'(sz == 0));
    chk("model.drop_count", 64'(drop_count), 64'(mdrop));
  endtask

  // One clock of the main instance: drive, advance model, wait edge, check.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic rdy, input logic clr);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = rdy;
    drop_clear    = clr;
    model_step(iv, d, rdy, clr);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    drop_clear     = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b0;
    drop_clear2    = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    mtag  = 0;
    mdrop = 0;
  endtask

  initial begin
    logic [7:0] prev_seq;
    int rdy_pct;

    rst = 1'b1;
    do_reset();

    // Reset values.
    chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset.out_data", 64'(bus.out_data), 64'd0);
    chk("reset.out_seq", 64'(bus.out_seq), 64'd0);
    chk("reset.level", 64'(level), 64'd0);
    chk("reset.full", 64'(full), 64'd0);
    chk("reset.empty", 64'(empty), 64'd1);
    chk("reset.drop_count", 64'(drop_count), 64'd0);
    $display("reset values checked");

    // Table: inputs before the edge, expected state after it.
    vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 8'd0, 4'd1, 16'd0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        8'd0, 4'd0, 16'd0};
    vecs[2] = '{1'b1, 32'h1234,     1'b0, 1'b0, 1'b1, 32'h1234,     8'd1, 4'd1, 16'd0};
    vecs[3] = '{1'b1, 32'h5678,     1'b0, 1'b0, 1'b1, 32'h1234,     8'd1, 4'd2, 16'd0};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h5678,     8'd2, 4'd1, 16'd0};
    vecs[5] = '{1'b1, 32'hAAAA,     1'b1, 1'b0, 1'b1, 32'hAAAA,     8'd3, 4'd1, 16'd0};
    vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        8'd0, 4'd0, 16'd0};
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      chk("vec.out_valid", 64'(bus.out_valid), 64'(vecs[i].e_ov));
      chk("vec.out_data", 64'(bus.out_data), 64'(vecs[i].e_data));
      chk("vec.out_seq", 64'(bus.out_seq), 64'(vecs[i].e_seq));
      chk("vec.level", 64'(level), 64'(vecs[i].e_lvl));
      chk("vec.drop_count", 64'(drop_count), 64'(vecs[i].e_drop));
      $display("vector %0d: in_valid=%0d data=0x%0h ready=%0d -> out_valid=%0d level=%0d",
               i, vecs[i].iv, vecs[i].d, vecs[i].rdy, bus.out_valid, level);
    end

    // Fill and overflow, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    chk("fill.level", 64'(level), 64'd8);
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.drop_count", 64'(drop_count), 64'd2);
    for (int i = 0; i < 8; i++) begin
      chk("drain.out_data", 64'(bus.out_data), 64'(i));
      chk("drain.out_seq", 64'(bus.out_seq), 64'(i));
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain.empty", 64'(empty), 64'd1);
    $display("fill/overflow/drain sequence done");

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      prev_seq = bus.out_seq;
      cycle(1'b1, 32'(200 + i), 1'b1, 1'b0);
      chk("fullpp.level", 64'(level), 64'd8);
      chk("fullpp.drop_count", 64'(drop_count), 64'd0);
      chk("fullpp.out_seq", 64'(bus.out_seq), 64'(prev_seq + 8'd1));
    end
    $display("full push+pop sequence done");

    // Clear colliding with a drop.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'(300 + i), 1'b0, 1'b0);
    chk("clr.drop5", 64'(drop_count), 64'd5);
    cycle(1'b1, 32'h999, 1'b0, 1'b1);
    chk("clr.collision", 64'(drop_count), 64'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("clr.alone", 64'(drop_count), 64'd0);
    $display("drop_clear sequence done");

    // Tag wrap with continuous flow.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 32'(i), 1'b1, 1'b0);
      chk("wrap.out_seq", 64'(bus.out_seq), 64'(i % 256));
      chk("wrap.level", 64'(level), 64'd1);
    end
    $display("tag wrap sequence done");

    // Saturation on the 4-bit counter instance: 8 stored, 20 dropped.
    do_reset();
    for (int i = 0; i < 28; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = 32'(i);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      if (i == 21) chk("sat.drop14", 64'(drop_count2), 64'd14);
    end
    bus2.in_valid = 1'b0;
    chk("sat.drop_count", 64'(drop_count2), 64'd15);
    chk("sat.full", 64'(full2), 64'd1);
    $display("saturation sequence done");

    // Reset mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'(50 + i), 1'b0, 1'b0);
    chk("midrst.level5", 64'(level), 64'd5);
    do_reset();
    chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst.empty", 64'(empty), 64'd1);
    chk("midrst.level", 64'(level), 64'd0);
    chk("midrst.out_data", 64'(bus.out_data), 64'd0);
    cycle(1'b1, 32'h77, 1'b0, 1'b0);
    chk("midrst.first_seq", 64'(bus.out_seq), 64'd0);
    chk("midrst.first_data", 64'(bus.out_data), 64'h77);
    $display("mid-stream reset sequence done");

    // Randomized traffic against the model, varying consumer pressure.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rdy_pct = (i < 500) ? 30 : ((i < 1000) ? 60 : 95);
      cycle($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 49) == 0);
    end
    $display("random run done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_result_buffer

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage for the ALU. Captures every result beat the ALU emits (the ALU has no stall input, so this block can never push back), tags it with a sequence number and holds it in a DEPTH-entry FIFO. Results leave on a valid/ready stream toward the consumer. Beats arriving while the FIFO is full are dropped and counted.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- WIDTH, 32, result data width; matches ALU output
- SEQ_W, 8, sequence tag width
- CNT_W, 16, drop counter width
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clock
- in_valid  in  1  ALU result valid; no ready is returned
- in_data  in  WIDTH  ALU result
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts the head entry
- out_data  out  WIDTH  head entry data
- out_seq  out  SEQ_W  sequence tag of the head entry
- level  out  $clog2(DEPTH+1)  current occupancy
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- drop_count  out  CNT_W  saturating count of dropped beats
- drop_clear  in  1  zeroes drop_count

## Operation
- pop = out_valid & out_ready; push_ok = in_valid & (!full | pop).
- Every in_valid beat consumes one tag value, whether or not it is stored. The tag counter increments by 1 modulo 2^SEQ_W. A gap in out_seq therefore marks a drop.
- Stored entry = {tag, in_data}. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally.
- Drop condition: in_valid & full & !pop. On a drop:
  - no write;
  - the tag still advances;
  - drop_count increments, saturating at 2^CNT_W-1.
- drop_clear: drop_count is set to 0 at the clock edge. If drop_clear and a drop occur in the same cycle, drop_count becomes 1 (clear is applied, then the count).
- level update: +1 on push_ok & !pop, -1 on pop & !push_ok, otherwise unchanged.
- out_valid = !empty.
- out_data and out_seq come from the read-pointer entry. They hold stable while out_valid & !out_ready.
- out_ready while empty has no effect.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_seq = 0;
  - level = 0, full = 0, empty = 1;
  - drop_count = 0;
  - pointers = 0, tag counter = 0.
- Reset mid-operation discards all stored entries. Storage contents need not be cleared, but out_data must read 0 while empty.
- Latency: a beat pushed at edge N is visible (out_valid = 1) in the cycle after edge N. It can pop at edge N+1 at the earliest.
- Throughput: 1 beat/cycle sustained when out_ready is held high. With out_ready high, an empty FIFO never drops.
- Full with simultaneous pop and in_valid: both occur and level stays at DEPTH. No drop.
- Empty with in_valid: push only. Same-cycle bypass to the output is not allowed.
- level, full and empty are registered-consistent. They reflect state after the last edge.
- Tag wrap: the value 2^SEQ_W-1 is followed by 0.

## Structure
- Shared package alu_pkg holds:
  - op_code_t (3-bit enum: AND, NAND, OR, NOR, XOR, XNOR, NOT_A, NOT_B);
  - ALU_DATA_W = 32;
  - default parameters for this block.
- One sub-module: sync_fifo, a generic parameterised WIDTH/DEPTH synchronous FIFO with push, pop, full, empty and level.
- alu_result_buffer wraps sync_fifo with the tagging, drop logic and saturating counter.

## Test plan
- Single beat: reset, then in_valid = 1, in_data = 0xDEADBEEF for one cycle, out_ready = 1 → next cycle out_valid = 1, out_data = 0xDEADBEEF, out_seq = 0; empty after the pop.
- Fill and overflow: out_ready = 0, 10 beats with data 0..9 → level = 8, full = 1, drop_count = 2. Then out_ready = 1 → data 0..7 with seq 0..7 drain in order.
- Full with simultaneous push and pop: hold the FIFO at level 8 with out_ready = 1 and in_valid = 1 for 20 cycles → drop_count stays 0, level stays 8, out_seq is contiguous.
- Clear collision: drop_count = 5, then drop_clear asserted in the same cycle as a drop → drop_count = 1. drop_clear alone → 0.
- Wrap and saturation: 300 continuous beats with out_ready = 1 → out_seq wraps from 255 to 0. Run with CNT_W = 4 and 20 drops → drop_count = 15.
- Reset mid-stream: reset with level = 5 → the next cycle shows out_valid = 0, empty = 1, level = 0. The first beat after reset carries seq 0.
